ahb_modport: RTL and testbench
==============================

// Module: ahb_modport
// PURPOSE
// - AHB-Lite/AHB-Full slave endpoint on the slave-side (cb_s) signal set of ahb_if.
// - Backs a word-addressed RAM with programmable wait states and decode-error responses.
// - Sits behind the interconnect decoder and is the default memory model for agent/VIP regressions.
// PARAMETERS
// ADDR_W       32     HADDR width
// DATA_W       32     HWDATA/HRDATA width (32 or 64)
// HMASTER_W    4      HMASTER width
// HRESP_W      2      HRESP width (1 = AHB5, 2 = AHB2); only bit0 is ever driven high
// MEM_WORDS    1024   RAM depth in DATA_W words; valid byte range 0 .. MEM_WORDS*DATA_W/8-1
// WAIT_STATES  0      HREADYOUT-low cycles inserted into every OKAY data phase (0..15)
// PORTS
// HCLK       in   1          clock, all state on posedge
// HRESETn    in   1          asynchronous active-low reset
// HSEL       in   1          slave select from decoder
// HADDR      in   ADDR_W     address
// HTRANS     in   2          IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
// HWRITE     in   1          1=write
// HSIZE      in   3          bytes = 1<<HSIZE
// HBURST     in   3          burst type, ignored (each beat decoded independently)
// HPROT      in   4          ignored
// HMASTLOCK  in   1          ignored
// HMASTER    in   HMASTER_W  ignored
// HWDATA     in   DATA_W     write data, valid in data phase
// HREADY     in   1          global ready (qualifies address phase)
// HREADYOUT  out  1          slave ready
// HRESP      out  HRESP_W    0=OKAY, 1=ERROR
// HRDATA     out  DATA_W     read data
// BEHAVIOUR
// - Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, no pending data phase; RAM contents not reset.
// - Address phase accepted on posedge when HSEL & HTRANS[1] & HREADY; registers addr, write, size.
// - IDLE/BUSY or HSEL=0: no data phase; next cycle HREADYOUT=1, HRESP=OKAY.
// - Error check at acceptance: addr beyond range, addr not aligned to size, or (1<<HSIZE) > DATA_W/8.
// - FSM: IDLE, WAIT, ERR1, ERR2.
//   IDLE --accept ok, WAIT_STATES>0--> WAIT; --accept ok, WAIT_STATES=0--> IDLE (1-cycle data phase).
//   WAIT counts WAIT_STATES cycles with HREADYOUT=0, HRESP=0, then one HREADYOUT=1 cycle.
//   IDLE --accept err--> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> IDLE; no RAM access.
// - Data phase completes in the cycle HREADYOUT=1.
//   Writes: commit HWDATA to the RAM on that posedge, byte lanes selected by size and addr low bits (little-endian).
//   Reads: HRDATA = full RAM word of the registered address in that cycle; 0 in every other cycle.
// - Pipelining: a new address phase is accepted in the same cycle a data phase completes; zero-wait back-to-back is one beat/cycle.
// - Read immediately after a write to the same word returns the new data; RAM read is combinational off the data-phase address.
// - Address/control changes while HREADYOUT=0 are ignored; the master holds them per protocol.
// - ERR2 always follows ERR1 regardless of the HTRANS value during ERR1; an address phase in ERR2 is accepted normally.
// - Reset mid-transfer aborts the data phase; any uncompleted write is discarded.
// STRUCTURE
// - Shared package ahb_pkg: htrans_e, hsize_e, hburst_e enums; HRESP_OKAY/HRESP_ERROR constants; byte-lane-mask function.
// - Sub-module ahb_modport_mem: DATA_W-wide RAM with byte-enable write port and combinational read port.
// - Top level: address-phase register, error decode, wait counter, 4-state FSM.
// TESTING
// - Reset: HRESETn=0 mid-cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously.
// - WAIT_STATES=0: NONSEQ write 0x10 data 0xDEADBEEF size=2, then read 0x10 -> HRDATA=0xDEADBEEF one cycle after the read address, no stalls.
// - Byte write: size=0 to 0x13 data 0xAA000000 over word 0x11223344 -> read back 0xAA223344.
// - WAIT_STATES=2: read -> HREADYOUT 0,0,1 and HRDATA valid only in the third data-phase cycle.
// - Error: addr 0x1002 size=2 (unaligned) or addr 0x1000 with MEM_WORDS=1024 -> HRESP=1 for two cycles, HREADYOUT 0 then 1; RAM unchanged.
// - HSEL=0 or HTRANS=BUSY with valid address -> no RAM write, HREADYOUT=1, HRESP=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the slave endpoint and its memory.
//   htrans_e / hsize_e / hburst_e : AHB transfer-type, size and burst encodings
//   HRESP_OKAY / HRESP_ERROR      : values of the low HRESP bit
//   lane_mask()                   : little-endian byte-lane enable for a transfer
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest data bus supported by lane_mask (128 bits).
  localparam int unsigned MAX_LANES = 16;

  // Byte lanes touched by a transfer of 1<<size bytes starting at lane lo.
  // Callers keep only the low DATA_W/8 bits; oversize transfers are rejected
  // before the mask is used.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [2:0] size,
                                                     input logic [3:0] lo);
    int unsigned nbytes;
    lane_mask = '0;
    nbytes    = 32'd1 << size;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      lane_mask[i] = (i >= 32'(lo)) && (i < 32'(lo) + nbytes);
    end
  endfunction

endpackage

// File: rtl/ahb_modport_mem.sv
// Word-organised RAM behind the AHB slave endpoint.
//   HCLK  : write clock
//   we    : write enable for this cycle
//   waddr : word index written
//   wbe   : per-byte write enables (bit b -> wdata[8b+7:8b])
//   wdata : write data
//   raddr : word index read (combinational)
//   rdata : read data
// Contents are not reset.
module ahb_modport_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned IDX_W     = 10
) (
  input  logic                HCLK,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned LANES = DATA_W / 8;

  logic [DATA_W-1:0] ram [MEM_WORDS];

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wbe[b]) ram[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = ram[raddr];

endmodule

// File: rtl/ahb_modport.sv
// AHB-Lite slave endpoint backed by a word-addressed RAM.
//   HCLK, HRESETn        : clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS  : select / address / transfer type of the address phase
//   HWRITE, HSIZE        : direction and size of the address phase
//   HBURST, HPROT,
//   HMASTLOCK, HMASTER   : accepted but unused (each beat decoded on its own)
//   HWDATA               : write data, valid in the data phase
//   HREADY               : bus ready, qualifies the address phase
//   HREADYOUT            : slave ready
//   HRESP                : bit0 = ERROR, upper bits always 0
//   HRDATA               : read data during a completing read, 0 otherwise
// Each OKAY data phase is stretched by WAIT_STATES low-ready cycles; bad
// addresses/sizes get the two-cycle ERROR response and never touch the RAM.
module ahb_modport
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HMASTER_W   = 4,
  parameter int unsigned HRESP_W     = 2,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDR_W-1:0]    HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic [HMASTER_W-1:0] HMASTER,
  input  logic [DATA_W-1:0]    HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic [HRESP_W-1:0]   HRESP,
  output logic [DATA_W-1:0]    HRDATA
);

  localparam int unsigned     LANES     = DATA_W / 8;
  localparam int unsigned     OFF_W     = $clog2(LANES);
  localparam int unsigned     IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam longint unsigned MEM_BYTES = longint'(MEM_WORDS) * longint'(LANES);
  localparam logic [3:0]      WS_LAST   = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e state, state_nxt;
  logic [3:0] wcnt, wcnt_nxt;

  // Registered data-phase context.
  logic             dp_valid;
  logic             dp_write;
  logic [IDX_W-1:0] dp_idx;
  logic [LANES-1:0] dp_be;

  htrans_e             trans;
  logic                hready_int;
  logic                accept;
  logic                acc_err;
  logic                bad_range, bad_align, bad_size;
  logic [7:0]          align_mask;
  logic [MAX_LANES-1:0] be_full;
  logic                complete;
  logic [DATA_W-1:0]   mem_rdata;
  logic                unused_ok;

  assign trans      = htrans_e'(HTRANS);
  assign hready_int = (state == ST_IDLE) || (state == ST_ERR2);

  // While we stall, the master holds address/control, so nothing is sampled.
  assign accept = HSEL && HREADY && hready_int &&
                  ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  assign align_mask = 8'((32'd1 << HSIZE) - 32'd1);
  assign bad_range  = 64'(HADDR) >= MEM_BYTES;
  assign bad_align  = |(8'(HADDR) & align_mask);
  assign bad_size   = (32'd1 << HSIZE) > LANES;
  assign acc_err    = bad_range || bad_align || bad_size;

  assign be_full = lane_mask(HSIZE, 4'(HADDR[OFF_W-1:0]));

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HMASTER, be_full};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      // A ready cycle retires the current data phase and opens the next one.
      if (hready_int) dp_valid <= accept && !acc_err;
      if (accept) begin
        dp_write <= HWRITE;
        dp_idx   <= HADDR[OFF_W +: IDX_W];
        dp_be    <= be_full[LANES-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    unique case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_nxt = ST_WAIT;
            wcnt_nxt  = WS_LAST;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt == '0) state_nxt = ST_IDLE;
        else            wcnt_nxt  = wcnt - 4'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // An OKAY data phase ends in the first IDLE-state cycle after acceptance.
  assign complete  = dp_valid && (state == ST_IDLE);
  assign HREADYOUT = hready_int;

  always_comb begin
    HRESP    = '0;
    HRESP[0] = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  assign HRDATA = (complete && !dp_write) ? mem_rdata : '0;

  ahb_modport_mem #(
    .DATA_W   (DATA_W),
    .MEM_WORDS(MEM_WORDS),
    .IDX_W    (IDX_W)
  ) u_mem (
    .HCLK (HCLK),
    .we   (complete && dp_write),
    .waddr(dp_idx),
    .wbe  (dp_be),
    .wdata(HWDATA),
    .raddr(dp_idx),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ahb_modport.sv
module tb_ahb_modport;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel0, hsel2;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;

  logic        ro0, ro2;
  logic [1:0]  rsp0, rsp2;
  logic [31:0] rd0, rd2;

  always #5 HCLK = ~HCLK;

  ahb_modport #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HMASTER(4'h0), .HWDATA(HWDATA), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0)
  );

  ahb_modport #(.WAIT_STATES(2)) u_dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HMASTER(4'h0), .HWDATA(HWDATA), .HREADY(ro2), .HREADYOUT(ro2), .HRESP(rsp2), .HRDATA(rd2)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  refm [2][4096];
  int          cur;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        rdy_c, hsel_c;
  logic [1:0]  rsp_c;
  logic [31:0] rd_c;

  assign rdy_c  = (cur == 1) ? ro2  : ro0;
  assign rsp_c  = (cur == 1) ? rsp2 : rsp0;
  assign rd_c   = (cur == 1) ? rd2  : rd0;
  assign hsel_c = (cur == 1) ? hsel2 : hsel0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd);
    for (int unsigned i = 0; i < (32'd1 << sz); i++)
      refm[d][a + i] = wd[8*((a + i) % 4) +: 8];
  endtask

  // Drive one address phase (data of the previous beat stays on HWDATA until
  // this one is accepted), push the expected data-phase result.
  task automatic beat(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                      input logic wr, input logic [2:0] size, input logic [31:0] wd);
    exp_t e;
    int unsigned nb;
    logic r;
    int n;
    hsel0  = sel && (cur == 0);
    hsel2  = sel && (cur == 1);
    HTRANS = trans;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    if (sel && trans[1]) begin
      nb       = 32'd1 << size;
      e.err    = (addr >= 32'd4096) || ((addr % nb) != 0) || (nb > 4);
      e.stalls = e.err ? 1 : ((cur == 1) ? 2 : 0);
      e.data   = '0;
      if (!e.err) begin
        if (wr) ref_write(cur, addr, size, wd);
        else for (int i = 0; i < 4; i++) e.data[8*i +: 8] = refm[cur][(addr & ~32'd3) + i];
      end
      q.push_back(e);
    end
    n = 0;
    do begin
      @(negedge HCLK);
      r = rdy_c;
      @(posedge HCLK);
      n++;
    end while (!r && n < 32);
    check_eq("accept", r, 1'b1);
    #1;
    if (sel && trans[1] && wr) HWDATA = wd;
  endtask

  task automatic idle();
    beat(1'b0, 2'b00, 32'h0, 1'b0, 3'd2, 32'h0);
  endtask

  // Data-phase monitor / scoreboard consumer.
  logic pend = 1'b0;
  int   stalls = 0;
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      pend = 1'b0;
      q.delete();
    end else begin
      if (pend) begin
        if (q.size() == 0) begin
          check_eq("sb_underflow", q.size(), 1);
          pend = 1'b0;
        end else if (rdy_c) begin
          e = q.pop_front();
          check_eq("dp_resp", rsp_c, {1'b0, e.err});
          check_eq("dp_rdata", rd_c, e.data);
          check_eq("dp_stalls", stalls, e.stalls);
          pend = 1'b0;
        end else begin
          stalls++;
          check_eq("stall_resp", rsp_c, {1'b0, q[0].err});
          check_eq("stall_rdata", rd_c, 32'h0);
        end
      end else begin
        check_eq("idle_ready", rdy_c, 1'b1);
        check_eq("idle_resp", rsp_c, 2'b00);
        check_eq("idle_rdata", rd_c, 32'h0);
      end
      if (rdy_c && hsel_c && HTRANS[1]) begin
        pend   = 1'b1;
        stalls = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs [8];
    cur = 0;
    HRESETn = 1'b0;
    hsel0 = 1'b0; hsel2 = 1'b0;
    HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = '0;
    for (int d = 0; d < 2; d++) for (int a = 0; a < 4096; a++) refm[d][a] = 8'h00;
    repeat (2) @(posedge HCLK);
    #1;
    check_eq("rst_ready0", ro0, 1'b1);
    check_eq("rst_resp0", rsp0, 2'b00);
    check_eq("rst_rdata0", rd0, 32'h0);
    HRESETn = 1'b1;

    // Zero-wait: write then read, pipelined.
    beat(1, 2'b10, 32'h10, 1, 3'd2, 32'hDEADBEEF);
    beat(1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
    // Byte and halfword lanes, read straight after the write.
    beat(1, 2'b10, 32'h10, 1, 3'd2, 32'h11223344);
    beat(1, 2'b10, 32'h13, 1, 3'd0, 32'hAA000000);
    beat(1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
    beat(1, 2'b10, 32'h14, 1, 3'd2, 32'h00000000);
    beat(1, 2'b11, 32'h16, 1, 3'd1, 32'hBEEF0000);
    beat(1, 2'b10, 32'h14, 0, 3'd2, 32'h0);
    // Errors: unaligned, out of range, oversize; RAM unchanged afterwards.
    beat(1, 2'b10, 32'h12, 1, 3'd2, 32'h55555555);
    beat(1, 2'b10, 32'h1002, 1, 3'd2, 32'h55555555);
    beat(1, 2'b10, 32'h1000, 1, 3'd2, 32'h55555555);
    beat(1, 2'b10, 32'h18, 0, 3'd3, 32'h0);
    beat(1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
    // Not selected / BUSY: no data phase, no write.
    beat(0, 2'b10, 32'h10, 1, 3'd2, 32'h0BAD0BAD);
    HWDATA = 32'h0BAD0BAD;
    beat(1, 2'b01, 32'h10, 1, 3'd2, 32'h0BAD0BAD);
    idle();
    beat(1, 2'b10, 32'h10, 0, 3'd2, 32'h0);
    // Random back-to-back words.
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'($urandom_range(0, 1023)) * 4;
      beat(1, 2'b10, addrs[i], 1, 3'd2, $urandom);
    end
    for (int i = 0; i < 8; i++) beat(1, 2'b10, addrs[i], 0, 3'd2, 32'h0);
    idle();
    idle();

    // Two wait states.
    cur = 1;
    idle();
    beat(1, 2'b10, 32'h20, 1, 3'd2, 32'hCAFEF00D);
    beat(1, 2'b10, 32'h20, 0, 3'd2, 32'h0);
    beat(1, 2'b10, 32'h22, 1, 3'd2, 32'h12345678);
    beat(1, 2'b10, 32'h20, 0, 3'd2, 32'h0);
    // Reset aborts a stalled write.
    beat(1, 2'b10, 32'h40, 1, 3'd2, 32'hA5A5A5A5);
    beat(1, 2'b10, 32'h40, 1, 3'd2, 32'h5A5A5A5A);
    #2;
    HRESETn = 1'b0;
    hsel2 = 1'b0;
    HTRANS = 2'b00;
    #1;
    check_eq("rst_async_ready", ro2, 1'b1);
    check_eq("rst_async_resp", rsp2, 2'b00);
    check_eq("rst_async_rdata", rd2, 32'h0);
    ref_write(1, 32'h40, 3'd2, 32'hA5A5A5A5);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    beat(1, 2'b10, 32'h40, 0, 3'd2, 32'h0);
    idle();
    idle();
    idle();
    idle();
    check_eq("sb_empty", q.size(), 0);
    check_eq("sb_pending", pend, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
